// File: rtl/bb_adc_seq_if.sv
// Handshake bundle between the VME read-request side / ADC front end and the BB ADC sequencer.
interface bb_adc_seq_if #(
  parameter int NCHAN = 4,
  parameter int CHW   = 2
);
  logic             strobe;
  logic             readbb;
  logic [NCHAN-1:0] chmask;
  logic             adcbusy;
  logic             bbconv;
  logic [CHW-1:0]   adcch;
  logic             dataready;
  logic [CHW-1:0]   donech;
  logic             lastch;
  logic             timeout;
  logic             active;

  modport master (
    output strobe, readbb, chmask, adcbusy,
    input  bbconv, adcch, dataready, donech, lastch, timeout, active
  );
  modport slave (
    input  strobe, readbb, chmask, adcbusy,
    output bbconv, adcch, dataready, donech, lastch, timeout, active
  );
endinterface

// File: rtl/bb_adc_seq.sv
// Multi-channel BB ADC sequencer: converts each enabled channel NCONV times, lowest index first,
// with a settle pause between conversions and a watchdog on the ADC busy handshake.
module bb_adc_seq #(
  parameter int NCHAN = 4,
  parameter int CHW   = 2,
  parameter int NCONV = 2,
  parameter int PAUSE = 7,
  parameter int TMO   = 255,
  parameter int TW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  bb_adc_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_WAIT, S_PAUSE, S_DATA, S_HOLD, S_ERR
  } state_t;

  state_t           state;
  logic [NCHAN-1:0] mask;
  logic [3:0]       conv;
  logic [7:0]       pcnt;
  logic [TW-1:0]    wd;
  logic [NCHAN-1:0] mask_rest;
  logic             wd_hit;

  function automatic logic [CHW-1:0] lowest_set(input logic [NCHAN-1:0] m);
    logic [CHW-1:0] r;
    r = '0;
    for (int i = NCHAN - 1; i >= 0; i--)
      if (m[i]) r = CHW'(i);
    return r;
  endfunction

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Mask with the channel being converted removed; anything left is a higher channel.
  assign mask_rest = mask & ~(NCHAN'(1) << bus.adcch);
  // The current cycle is the TMO-th one spent in CONV/WAIT_BUSY.
  assign wd_hit    = (wd >= TW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mask          <= '0;
      conv          <= '0;
      pcnt          <= '0;
      wd            <= '0;
      bus.bbconv    <= 1'b0;
      bus.adcch     <= '0;
      bus.dataready <= 1'b0;
      bus.donech    <= '0;
      bus.lastch    <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.active    <= 1'b0;
    end else begin
      bus.dataready <= 1'b0;
      bus.lastch    <= 1'b0;
      bus.timeout   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.strobe && bus.readbb && (bus.chmask != '0)) begin
            state      <= S_CONV;
            mask       <= bus.chmask;
            bus.adcch  <= lowest_set(bus.chmask);
            conv       <= '0;
            wd         <= '0;
            bus.bbconv <= 1'b1;
            bus.active <= 1'b1;
          end
        end
        S_CONV: begin
          wd <= sat_inc(wd);
          if (wd_hit) begin
            state       <= S_ERR;
            bus.bbconv  <= 1'b0;
            bus.timeout <= 1'b1;
          end else if (bus.adcbusy) begin
            state      <= S_WAIT;
            bus.bbconv <= 1'b0;
          end
        end
        S_WAIT: begin
          wd <= sat_inc(wd);
          if (wd_hit) begin
            state       <= S_ERR;
            bus.timeout <= 1'b1;
          end else if (!bus.adcbusy) begin
            conv <= conv + 4'd1;
            if ((conv + 4'd1) < 4'(NCONV)) begin
              state <= S_PAUSE;
              pcnt  <= '0;
            end else begin
              state         <= S_DATA;
              mask          <= mask_rest;
              bus.dataready <= 1'b1;
              bus.donech    <= bus.adcch;
              bus.lastch    <= (mask_rest == '0);
            end
          end
        end
        S_PAUSE: begin
          if (pcnt == 8'(PAUSE - 1)) begin
            state      <= S_CONV;
            wd         <= '0;
            bus.bbconv <= 1'b1;
          end else begin
            pcnt <= pcnt + 8'd1;
          end
        end
        S_DATA: begin
          if (mask != '0) begin
            state     <= S_PAUSE;
            pcnt      <= '0;
            conv      <= '0;
            bus.adcch <= lowest_set(mask);
          end else begin
            state <= S_HOLD;
          end
        end
        S_HOLD, S_ERR: begin
          if (!bus.strobe) begin
            state      <= S_IDLE;
            bus.active <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          bus.bbconv <= 1'b0;
          bus.active <= 1'b0;
        end
      endcase
    end
  end

endmodule
